store_align_buffer: RTL

//  Store-side counterpart of the load-path sign/zero extender: narrows 32-bit register data to byte/half/word stores.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/store_lane_align.sv | 34 +++
 rtl/store_align_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared store-path types: access-size codes and queued store entry.
// Lane payload is split out so the aligner can return it as one bundle.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned ENTRY_AW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } lane_t;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         data;
    logic [3:0]          be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane placement and byte-enable generation.
// Reserved size 2'b11 is handled as a word access.
module store_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output lane_t       lane,
  output logic        misaligned
);

  always_comb begin
    lane       = '0;
    misaligned = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        lane.data = {4{data[7:0]}};
        lane.be   = 4'b0001 << off;
      end
      (size == SZ_HALF): begin
        lane.data  = {2{data[15:0]}};
        lane.be    = off[1] ? 4'b1100 : 4'b0011;
        misaligned = off[0];
      end
      default: begin
        lane.data  = data;
        lane.be    = 4'b1111;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store lane aligner plus FIFO between MEM stage and data-memory port.
// Define MISALIGN_TRAP_EN to drop misaligned stores and flag them.
module store_align_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [1:0]               in_size,
  input  logic [31:0]              in_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_data,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     misalign_err,
  output logic [ADDR_W-1:0]        err_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  lane_t             lane_q [DEPTH];
  lane_t             lane;
  logic              mis;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              enq;

  store_lane_align u_align (
    .off        (in_addr[1:0]),
    .size       (in_size),
    .data       (in_data),
    .lane       (lane),
    .misaligned (mis)
  );

  // extra pointer bit separates full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign in_ready  = !full;
  assign mem_valid = !empty;
  assign count     = wr_ptr - rd_ptr;

  assign push = in_valid && in_ready;
  assign pop  = mem_valid && mem_ready;

`ifdef MISALIGN_TRAP_EN
  assign enq = push && !mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      misalign_err <= push && mis;
      if (push && mis) err_addr <= in_addr;
    end
  end
`else
  logic unused_mis;
  assign unused_mis   = mis;
  assign enq          = push;
  assign misalign_err = 1'b0;
  assign err_addr     = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        lane_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr[PW-1:0]] <= {in_addr[ADDR_W-1:2], 2'b00};
        lane_q[wr_ptr[PW-1:0]] <= lane;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign mem_addr = addr_q[rd_ptr[PW-1:0]];
  assign mem_data = lane_q[rd_ptr[PW-1:0]].data;
  assign mem_be   = lane_q[rd_ptr[PW-1:0]].be;

endmodule
